// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives int_mem, and queues {pc, instr}
// pairs for decode behind a valid/ready handshake; redirects flush and reload.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter logic [32:0] MEM_BYTES = 33'd1024
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc4,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [31:0]   pc_r;
  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  logic          pop_s;
  logic          push_s;
  logic          halted_s;
  logic [63:0]   head_s;

  // Handshake and fetch-enable decode; a full queue may refill while it pops.
  always_comb begin
    halted_s = 1'b0;
    pop_s    = 1'b0;
    push_s   = 1'b0;
    head_s   = mem_r[rd_ptr_r];
    if ({1'b0, pc_r} >= MEM_BYTES) begin
      halted_s = 1'b1;
    end else begin
      halted_s = 1'b0;
    end
    pop_s  = (count_r != {CW{1'b0}}) & out_ready;
    push_s = ~redirect & ((count_r < CNT_DEPTH) | pop_s) & ~halted_s;
  end

  // PC, queue storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r     <= RESET_PC;
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
    end else if (redirect) begin
      // Any same-cycle pop was already taken by decode; the queue just empties.
      pc_r     <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {pc_r, imem_data};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
        pc_r            <= pc_r + 32'd4;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign imem_addr = pc_r;
  assign out_valid = (count_r != {CW{1'b0}});
  assign out_pc    = head_s[63:32];
  assign out_instr = head_s[31:0];
  assign out_pc4   = head_s[63:32] + 32'd4;
  assign count     = count_r;
  assign halted    = halted_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a default instance and a 16-byte-memory
// instance for the halt boundary; monitors pop expected PCs on each handshake.
module tb_fetch_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, rst2;
  logic        redirect, redirect2;
  logic [31:0] redirect_pc, redirect_pc2;
  logic        out_ready, out_ready2;
  logic [31:0] imem_addr, imem_data, out_instr, out_pc, out_pc4;
  logic [31:0] imem_addr2, imem_data2, out_instr2, out_pc2, out_pc42;
  logic        out_valid, out_valid2, halted, halted2;
  logic [2:0]  count, count2;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] sb2[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 + (a >> 2);
  endfunction

  assign imem_data  = word(imem_addr);
  assign imem_data2 = word(imem_addr2);

  fetch_unit dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc4(out_pc4), .count(count), .halted(halted)
  );

  fetch_unit #(.MEM_BYTES(33'd16)) dut2 (
    .clock(clock), .reset(rst2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2),
    .out_pc4(out_pc42), .count(count2), .halted(halted2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Main-instance monitor: one expected entry per accepted head.
  always @(negedge clock) begin : mon1
    logic [31:0] e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL main_unexpected_pop: got pc %h expected no entry", out_pc);
      end else begin
        e = sb.pop_front();
        check("main_pc", out_pc, e);
        check("main_instr", out_instr, word(e));
        check("main_pc4", out_pc4, e + 32'd4);
      end
    end
  end

  // Halt-instance monitor.
  always @(negedge clock) begin : mon2
    logic [31:0] e;
    if (!rst2 && out_valid2 && out_ready2) begin
      if (sb2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL halt_unexpected_pop: got pc %h expected no entry", out_pc2);
      end else begin
        e = sb2.pop_front();
        check("halt_pc", out_pc2, e);
        check("halt_instr", out_instr2, word(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rst2 = 1'b1;
    redirect = 1'b0; redirect2 = 1'b0;
    redirect_pc = 32'd0; redirect_pc2 = 32'd0;
    out_ready = 1'b0; out_ready2 = 1'b0;

    // Reset state
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_pc4", out_pc4, 32'd4);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_halted2", 32'(halted2), 32'd0);

    // Streaming with decode always ready
    #10;
    reset = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) sb.push_back(32'(4 * k));
    for (int k = 1; k <= 6; k++) begin
      step();
      check("stream_count", 32'(count), 32'd1);
      check("stream_addr", imem_addr, 32'(4 * k));
    end
    out_ready = 1'b0;
    step();
    check("pre_reset_count", 32'(count), 32'd2);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_addr", imem_addr, 32'd0);
    #3;
    reset = 1'b0;

    // Stall and fill, then full queue with simultaneous push/pop
    for (int k = 0; k < 5; k++) sb.push_back(32'(4 * k));
    for (int k = 1; k <= 4; k++) begin
      step();
      check("fill_count", 32'(count), 32'(k));
      check("fill_addr", imem_addr, 32'(4 * k));
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check("stall_count", 32'(count), 32'd4);
      check("stall_addr", imem_addr, 32'd16);
    end
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      check("full_count", 32'(count), 32'd4);
      check("full_addr", imem_addr, 32'(16 + 4 * j));
      check("full_head", out_pc, 32'(4 * j));
    end

    // Back-to-back redirects: last wins, nothing pushed
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    check("redir1_count", 32'(count), 32'd0);
    check("redir1_valid", 32'(out_valid), 32'd0);
    check("redir1_addr", imem_addr, 32'h0000_0100);
    redirect_pc = 32'h0000_0200;
    step();
    check("redir2_count", 32'(count), 32'd0);
    check("redir2_addr", imem_addr, 32'h0000_0200);
    redirect = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("refill_count", 32'(count), 32'(k));
    end

    // Redirect with 3 queued and a same-cycle pop of the head
    sb.push_back(32'h0000_0200);
    sb.push_back(32'h0000_0040);
    sb.push_back(32'h0000_0044);
    redirect = 1'b1; redirect_pc = 32'h0000_0043; out_ready = 1'b1;
    step();
    check("redir_count", 32'(count), 32'd0);
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h0000_0040);
    redirect = 1'b0;
    step();
    check("target_valid", 32'(out_valid), 32'd1);
    check("target_pc", out_pc, 32'h0000_0040);
    check("target_pc4", out_pc4, 32'h0000_0044);
    check("target_count", 32'(count), 32'd1);
    step();
    step();
    out_ready = 1'b0;

    // Halt boundary on the 16-byte instance
    sb2.push_back(32'd0);
    sb2.push_back(32'd4);
    sb2.push_back(32'd8);
    sb2.push_back(32'd12);
    sb2.push_back(32'd4);
    rst2 = 1'b0; out_ready2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("halt_addr", imem_addr2, 32'(4 * k));
      check("halt_flag", 32'(halted2), (k == 4) ? 32'd1 : 32'd0);
    end
    step();
    check("halt_drain_valid", 32'(out_valid2), 32'd0);
    check("halt_drain_count", 32'(count2), 32'd0);
    check("halt_still", 32'(halted2), 32'd1);
    step();
    check("halt_idle_valid", 32'(out_valid2), 32'd0);
    check("halt_idle_addr", imem_addr2, 32'd16);
    redirect2 = 1'b1; redirect_pc2 = 32'd4;
    step();
    check("unhalt_flag", 32'(halted2), 32'd0);
    check("unhalt_addr", imem_addr2, 32'd4);
    check("unhalt_valid", 32'(out_valid2), 32'd0);
    redirect2 = 1'b0;
    step();
    check("resume_valid", 32'(out_valid2), 32'd1);
    check("resume_pc", out_pc2, 32'd4);
    step();
    out_ready2 = 1'b0;

    #10;
    check("main_sb_empty", 32'(sb.size()), 32'd0);
    check("halt_sb_empty", 32'(sb2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
